// File: rtl/scpu_pkg.sv
// Shared definitions for the single-cycle CPU datapath.
//   SCPU_DATA_W : default register/data width
//   SCPU_ADDR_W : default register index width
//   REG_ZERO    : index of the hardwired-zero register
package scpu_pkg;

    localparam int SCPU_DATA_W = 32;
    localparam int SCPU_ADDR_W = 5;
    localparam int REG_ZERO    = 0;

endpackage

// File: rtl/regs_read_port.sv
// One combinational read port of the register file.
//   addr    : register index to read
//   rf      : flattened register contents (entry 0 is constant zero)
//   wr_en   : qualified write enable (already gated by reset)
//   wd_addr : write index
//   wd_data : write data
//   data    : read result
// BYPASS=1 forwards the in-flight write data when the write index matches.
module regs_read_port
    import scpu_pkg::*;
#(
    parameter int DATA_W = SCPU_DATA_W,
    parameter int ADDR_W = SCPU_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0]                     addr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]      rf,
    input  logic                                  wr_en,
    input  logic [ADDR_W-1:0]                     wd_addr,
    input  logic [DATA_W-1:0]                     wd_data,
    output logic [DATA_W-1:0]                     data
);

    always_comb begin
        data = rf[addr];
        if (BYPASS && wr_en && (wd_addr != ADDR_W'(REG_ZERO)) && (wd_addr == addr)) begin
            data = wd_data;
        end
        // Register zero wins over any forwarding.
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regs_scpu.sv
// General-purpose register file for the single-cycle CPU.
//   clk      : clock, writes on rising edge
//   rst_n    : asynchronous active-low reset, clears all registers
//   rs_addr  / rs_data  : read port 1 (ALU A operand)
//   rt_addr  / rt_data  : read port 2 (ALU B-side mux)
//   we, wd_addr, wd_data: write-back port
//   dbg_addr / dbg_data : debug read port, never forwarded
// Register 0 has no storage and always reads as zero.
module regs_scpu
    import scpu_pkg::*;
#(
    parameter int DATA_W = SCPU_DATA_W,
    parameter int ADDR_W = SCPU_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wd_addr,
    input  logic [DATA_W-1:0] wd_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0]            mem [1:NREG-1];
    logic [NREG-1:0][DATA_W-1:0]  rf;
    logic                         wr_en;

    // Forwarding must not leak write data onto the read ports while
    // reset is held, so the enable seen by the ports is reset-qualified.
    assign wr_en = we & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < NREG; k++) begin
                mem[k] <= '0;
            end
        end else if (we && (wd_addr != ADDR_W'(REG_ZERO))) begin
            mem[wd_addr] <= wd_data;
        end
    end

    always_comb begin
        rf[0] = '0;
        for (int k = 1; k < NREG; k++) begin
            rf[k] = mem[k];
        end
    end

    regs_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rs (
        .addr    (rs_addr),
        .rf      (rf),
        .wr_en   (wr_en),
        .wd_addr (wd_addr),
        .wd_data (wd_data),
        .data    (rs_data)
    );

    regs_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rt (
        .addr    (rt_addr),
        .rf      (rf),
        .wr_en   (wr_en),
        .wd_addr (wd_addr),
        .wd_data (wd_data),
        .data    (rt_data)
    );

    regs_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_dbg (
        .addr    (dbg_addr),
        .rf      (rf),
        .wr_en   (wr_en),
        .wd_addr (wd_addr),
        .wd_data (wd_data),
        .data    (dbg_data)
    );

endmodule
